// File: rtl/sipo_loader_4bit_pkg.sv
// rtl/sipo_loader_4bit_pkg.sv - shared state encoding and sizing for the serial-in parallel-out loader
package sipo_loader_4bit_pkg;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2,
    S_OUT  = 2'd3
  } state_e;

endpackage

// File: rtl/sipo_loader_4bit_if.sv
// rtl/sipo_loader_4bit_if.sv - serial handshake in, parallel word/pulse out
interface sipo_loader_4bit_if #(
  parameter int WIDTH = 4
);
  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             load;
  logic             par_err;
  logic             busy;

  modport master (
    output ser_in, ser_valid, flush,
    input  ser_ready, d, load, par_err, busy
  );

  modport slave (
    input  ser_in, ser_valid, flush,
    output ser_ready, d, load, par_err, busy
  );
endinterface

// File: rtl/sipo_loader_4bit.sv
// rtl/sipo_loader_4bit.sv - collects serial bits, optionally checks parity, emits a word with a load pulse
module sipo_loader_4bit
  import sipo_loader_4bit_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               clear_n,
  sipo_loader_4bit_if.slave  sif
);

  localparam int CW = (WIDTH == DEF_WIDTH) ? CNT_W : cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             load_q, load_d;
  logic             par_err_q, par_err_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shifted;
  logic             accept;
  logic             last_data;
  logic             par_ok;

  // OUT blocks intake so the source holds its bit until the word is committed
  assign sif.ser_ready = clear_n && (state_q != S_OUT);
  assign accept        = sif.ser_valid && sif.ser_ready;
  assign last_data     = (cnt_q == CW'(WIDTH - 1));
  assign par_ok        = (sif.ser_in == ((^shift_q) ^ PARITY_ODD));

  always_comb begin
    shifted = '0;
    if (MSB_FIRST) begin
      shifted = (shift_q << 1) | WIDTH'(sif.ser_in);
    end else begin
      shifted = (shift_q >> 1) | (WIDTH'(sif.ser_in) << (WIDTH - 1));
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    d_d       = d_q;
    load_d    = 1'b0;
    par_err_d = 1'b0;

    case (state_q)
      S_IDLE, S_DATA: begin
        if (sif.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end else if (accept) begin
          if (last_data) begin
            cnt_d = '0;
            if (PARITY_EN) begin
              state_d = S_PAR;
              shift_d = shifted;
            end else begin
              state_d = S_OUT;
              d_d     = shifted;
              load_d  = 1'b1;
              shift_d = '0;
            end
          end else begin
            state_d = S_DATA;
            cnt_d   = cnt_q + CW'(1);
            shift_d = shifted;
          end
        end
      end

      S_PAR: begin
        if (sif.flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          shift_d = '0;
        end else if (accept) begin
          shift_d = '0;
          if (par_ok) begin
            state_d = S_OUT;
            d_d     = shift_q;
            load_d  = 1'b1;
          end else begin
            state_d   = S_IDLE;
            par_err_d = 1'b1;
          end
        end
      end

      S_OUT: begin
        // flush is ignored here: the word is already committed
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase

    busy_d = (state_d == S_DATA) || (state_d == S_PAR);
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      d_q       <= '0;
      load_q    <= 1'b0;
      par_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      d_q       <= d_d;
      load_q    <= load_d;
      par_err_q <= par_err_d;
      busy_q    <= busy_d;
    end
  end

  assign sif.d       = d_q;
  assign sif.load    = load_q;
  assign sif.par_err = par_err_q;
  assign sif.busy    = busy_q;

endmodule

// File: tb/tb_sipo_loader_4bit.sv
// tb/tb_sipo_loader_4bit.sv - directed bench over MSB-first, LSB-first and even-parity loader instances
module tb_sipo_loader_4bit;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       s_in = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_flush = 1'b0;
  int         sel = 0;

  logic       r_ready, r_load, r_par_err, r_busy;
  logic [3:0] r_d;

  int errors = 0;
  int checks = 0;
  int load_cnt = 0;

  always #5 clk = ~clk;

  sipo_loader_4bit_if #(.WIDTH(4)) if0 ();
  sipo_loader_4bit_if #(.WIDTH(4)) if1 ();
  sipo_loader_4bit_if #(.WIDTH(4)) if2 ();

  assign if0.ser_in    = s_in;
  assign if1.ser_in    = s_in;
  assign if2.ser_in    = s_in;
  assign if0.ser_valid = s_valid && (sel == 0);
  assign if1.ser_valid = s_valid && (sel == 1);
  assign if2.ser_valid = s_valid && (sel == 2);
  assign if0.flush     = s_flush && (sel == 0);
  assign if1.flush     = s_flush && (sel == 1);
  assign if2.flush     = s_flush && (sel == 2);

  sipo_loader_4bit #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut_msb (.clk(clk), .clear_n(clear_n), .sif(if0));
  sipo_loader_4bit #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    dut_lsb (.clk(clk), .clear_n(clear_n), .sif(if1));
  sipo_loader_4bit #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    dut_par (.clk(clk), .clear_n(clear_n), .sif(if2));

  always_comb begin
    case (sel)
      1: begin
        r_ready = if1.ser_ready; r_load = if1.load; r_par_err = if1.par_err;
        r_busy = if1.busy; r_d = if1.d;
      end
      2: begin
        r_ready = if2.ser_ready; r_load = if2.load; r_par_err = if2.par_err;
        r_busy = if2.busy; r_d = if2.d;
      end
      default: begin
        r_ready = if0.ser_ready; r_load = if0.load; r_par_err = if0.par_err;
        r_busy = if0.busy; r_d = if0.d;
      end
    endcase
  end

  always @(posedge clk) if (r_load) load_cnt <= load_cnt + 1;

  typedef struct {
    int         sel;
    logic [3:0] bits;
    logic       par;
    logic [3:0] exp_d;
    logic       exp_load;
    logic       exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one bit and returns 1ns after the edge that took it
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    s_in = b;
    s_valid = 1'b1;
    while (!r_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_wait", r_ready, 1'b1);
    if (r_ready) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] b, input logic use_par, input logic p);
    for (int i = 3; i >= 0; i--) send_bit(b[i]);
    if (use_par) send_bit(p);
  endtask

  initial begin
    int         lc0;
    logic [3:0] sbits [8];
    int         idx, cyc, nloads;
    int         lcyc [2];
    logic [3:0] ld [2];
    logic       acc;

    vecs[0] = '{0, 4'b1011, 1'b0, 4'b1011, 1'b1, 1'b0};
    vecs[1] = '{1, 4'b1011, 1'b0, 4'b1101, 1'b1, 1'b0};
    vecs[2] = '{2, 4'b1011, 1'b1, 4'b1011, 1'b1, 1'b0};
    vecs[3] = '{2, 4'b0001, 1'b0, 4'b1011, 1'b0, 1'b1};
    vecs[4] = '{0, 4'b0110, 1'b0, 4'b0110, 1'b1, 1'b0};
    vecs[5] = '{1, 4'b0011, 1'b0, 4'b1100, 1'b1, 1'b0};
    vecs[6] = '{2, 4'b1100, 1'b0, 4'b1100, 1'b1, 1'b0};
    vecs[7] = '{2, 4'b1110, 1'b0, 4'b1100, 1'b0, 1'b1};

    // reset state
    idle(2);
    chk("rst_ready", r_ready, 1'b0);
    chk("rst_d", r_d, 4'b0000);
    chk("rst_load", r_load, 1'b0);
    chk("rst_par_err", r_par_err, 1'b0);
    chk("rst_busy", r_busy, 1'b0);
    clear_n = 1'b1;
    #1;
    chk("post_rst_ready", r_ready, 1'b1);

    for (int v = 0; v < 8; v++) begin
      sel = vecs[v].sel;
      #1;
      send_word(vecs[v].bits, vecs[v].sel == 2, vecs[v].par);
      chk($sformatf("v%0d_load", v), r_load, vecs[v].exp_load);
      chk($sformatf("v%0d_par_err", v), r_par_err, vecs[v].exp_err);
      chk($sformatf("v%0d_d", v), r_d, vecs[v].exp_d);
      chk($sformatf("v%0d_ready", v), r_ready, !vecs[v].exp_load);
      chk($sformatf("v%0d_busy", v), r_busy, 1'b0);
      idle(1);
      chk($sformatf("v%0d_load_end", v), r_load, 1'b0);
      chk($sformatf("v%0d_err_end", v), r_par_err, 1'b0);
      chk($sformatf("v%0d_d_hold", v), r_d, vecs[v].exp_d);
    end

    // bits separated by idle gaps
    sel = 0;
    #1;
    lc0 = load_cnt;
    send_bit(1'b1);
    chk("gap_busy_first", r_busy, 1'b1);
    idle(2);
    chk("gap_busy_idle", r_busy, 1'b1);
    send_bit(1'b0);
    idle(2);
    send_bit(1'b1);
    idle(2);
    send_bit(1'b1);
    chk("gap_load", r_load, 1'b1);
    chk("gap_d", r_d, 4'b1011);
    chk("gap_busy_out", r_busy, 1'b0);
    idle(2);
    chk("gap_load_count", load_cnt - lc0, 1);

    // flush aborts a partial word; flush during OUT is ignored
    lc0 = load_cnt;
    send_bit(1'b1);
    send_bit(1'b1);
    s_flush = 1'b1;
    idle(1);
    s_flush = 1'b0;
    chk("flush_busy", r_busy, 1'b0);
    chk("flush_d_hold", r_d, 4'b1011);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    s_flush = 1'b1;
    chk("flush_out_load", r_load, 1'b1);
    chk("flush_out_d", r_d, 4'b0110);
    idle(1);
    s_flush = 1'b0;
    chk("flush_after_load", r_load, 1'b0);
    chk("flush_after_d", r_d, 4'b0110);
    idle(1);
    chk("flush_load_count", load_cnt - lc0, 1);

    // reset in the middle of a word
    send_word(4'b1011, 1'b0, 1'b0);
    chk("pre_rst_d", r_d, 4'b1011);
    idle(1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    clear_n = 1'b0;
    #1;
    chk("mid_rst_ready", r_ready, 1'b0);
    idle(1);
    chk("mid_rst_d", r_d, 4'b0000);
    chk("mid_rst_load", r_load, 1'b0);
    chk("mid_rst_busy", r_busy, 1'b0);
    clear_n = 1'b1;
    #1;
    send_word(4'b0101, 1'b0, 1'b0);
    chk("after_rst_load", r_load, 1'b1);
    chk("after_rst_d", r_d, 4'b0101);
    idle(1);

    // continuous stream with ser_valid held high across two words
    sbits = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    idx = 0;
    cyc = 0;
    nloads = 0;
    lcyc = '{0, 0};
    ld = '{4'b0, 4'b0};
    s_in = sbits[0];
    s_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      acc = s_valid && r_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) idx++;
      if (r_load) begin
        if (nloads < 2) begin
          lcyc[nloads] = cyc;
          ld[nloads] = r_d;
        end
        nloads++;
      end
      if (idx < 8) s_in = sbits[idx];
      else s_valid = 1'b0;
    end
    s_valid = 1'b0;
    chk("stream_loads", nloads, 2);
    chk("stream_bits_taken", idx, 8);
    chk("stream_word0", ld[0], 4'b1001);
    chk("stream_word1", ld[1], 4'b0111);
    chk("stream_spacing", lcyc[1] - lcyc[0], 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
